register_bus_master: RTL
========================

// Module: register_bus_master
//
// PURPOSE
//   Initiator side of the 8-bit storage-register interface. Turns one-cycle
//   upstream REQ transactions into correctly timed active-low write strobes
//   (EWR) and read enables (EDY). Drives the register's DATA inputs and
//   samples its OUTRESULT. Optional write-then-readback verify flags
//   corrupted stores. Sits between the ALU/filter datapath and the register.
//
// PARAMETERS
//   NUMBITS     7   MSB index of the data bus (bus width = NUMBITS+1)
//   STROBE_CYC  2   cycles EWR is held low per write; legal range >= 1
//   READ_WAIT   1   EDY-low settle cycles before sampling; legal range >= 0
//   VERIFY      0   1 = every write is followed by a readback compare
//
// PORTS
//   CLOCK     in   1          system clock; all logic on the rising edge
//   RESET     in   1          synchronous, active-low reset
//   REQ       in   1          transaction request; sampled in IDLE only
//   WR        in   1          1 = write, 0 = read; captured with REQ
//   WDATA     in   NUMBITS+1  write data; captured with REQ
//   REG_IN    in   NUMBITS+1  register OUTRESULT
//   DATA_OUT  out  NUMBITS+1  to register DATA
//   EWR       out  1          register write strobe, active low
//   EDY       out  1          register output enable, active low
//   BUSY      out  1          high in every state except IDLE
//   ACK       out  1          one-cycle completion pulse
//   RDATA     out  NUMBITS+1  data from the last read or verify
//   MISMATCH  out  1          verify failure; sticky
//
// BEHAVIOUR
//   - Reset (RESET=0 at an edge): state IDLE. EWR=1, EDY=1, BUSY=0, ACK=0,
//     MISMATCH=0. DATA_OUT=0 and RDATA=0. Counters are cleared.
//   - Reset mid-transaction aborts at that edge. No ACK is issued.
//     The strobes return to 1 and the transaction is lost.
//   - FSM states: IDLE, W_SETUP, W_STROBE, W_HOLD, R_ENABLE, R_SAMPLE, DONE.
//   - IDLE, REQ=1:
//       * Capture WR and WDATA. Clear MISMATCH.
//       * Go to W_SETUP if WR=1, else R_ENABLE (R_SAMPLE if READ_WAIT=0).
//   - REQ outside IDLE is ignored; there is no queueing.
//   - Write sequence:
//       * W_SETUP: 1 cycle. DATA_OUT = captured data, EWR=1.
//       * W_STROBE: STROBE_CYC cycles with EWR=0.
//       * W_HOLD: 1 cycle. EWR=1, DATA_OUT unchanged.
//       * Then DONE, or R_ENABLE/R_SAMPLE if VERIFY=1.
//   - Read sequence:
//       * R_ENABLE: READ_WAIT cycles with EDY=0.
//       * R_SAMPLE: 1 cycle with EDY=0. RDATA <= REG_IN at its closing edge.
//       * Then DONE.
//   - DONE: 1 cycle. ACK=1, EWR=1, EDY=1. Next state is IDLE.
//   - Verify: at the R_SAMPLE closing edge, MISMATCH <= (REG_IN != WDATA).
//   - Latency, with the accept edge as cycle 0:
//       * ACK high on cycle 3+STROBE_CYC for a write.
//       * ACK high on cycle READ_WAIT+2 for a read.
//       * A verified write adds READ_WAIT+1 cycles.
//   - Back-to-back: REQ held high is accepted again in the IDLE cycle after
//     DONE. Minimum spacing is therefore ACK + 1 idle cycle.
//   - EWR and EDY are never low in the same cycle.
//   - Outputs are registered, with no combinational path from REQ.
//   - DATA_OUT keeps its last value outside write sequences.
//
// TESTING
//   1. Reset: hold RESET=0 for 2 cycles -> EWR=1, EDY=1, BUSY=0, ACK=0,
//      RDATA=8'h00, MISMATCH=0.
//   2. Write 8'hA5 (defaults): DATA_OUT=8'hA5 from cycle 1; EWR=0 on cycles
//      2-3 only; ACK on cycle 5; BUSY high on cycles 1-5.
//   3. Read with REG_IN=8'h3C: EDY=0 on cycles 1-2; ACK on cycle 3 with
//      RDATA=8'h3C. Repeat with READ_WAIT=0 -> ACK on cycle 2.
//   4. VERIFY=1, write 8'h0F. Model returns 8'h0F -> MISMATCH=0. Model
//      returns 8'h0E -> MISMATCH=1 at ACK; it clears on the next accepted REQ.
//   5. Hold REQ=1 continuously, alternating write/read -> each new accept
//      occurs in the cycle after ACK. REQ pulses during BUSY are ignored.
//   6. Assert RESET=0 during W_STROBE -> EWR=1 at the next edge, no ACK,
//      IDLE afterwards. Check EWR&EDY are never both 0 on every cycle.

Source files
------------

// File: rtl/register_bus_master.sv
// ============================================================================
// register_bus_master : strobe/enable sequencer for the 8-bit storage register
// Rev 1.0
// ============================================================================
`default_nettype none

module register_bus_master #(
  parameter int NUMBITS    = 7,
  parameter int STROBE_CYC = 2,
  parameter int READ_WAIT  = 1,
  parameter int VERIFY     = 0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             REQ,
  input  logic             WR,
  input  logic [NUMBITS:0] WDATA,
  input  logic [NUMBITS:0] REG_IN,
  output logic [NUMBITS:0] DATA_OUT,
  output logic             EWR,
  output logic             EDY,
  output logic             BUSY,
  output logic             ACK,
  output logic [NUMBITS:0] RDATA,
  output logic             MISMATCH
);

  localparam int MAX_CNT = (STROBE_CYC > READ_WAIT) ? STROBE_CYC : READ_WAIT;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] READ_LOAD   = CNT_W'((READ_WAIT > 0) ? READ_WAIT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_ENABLE = 3'd4,
    R_SAMPLE = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [NUMBITS:0]   data_q, data_d;
  logic [NUMBITS:0]   rdata_q, rdata_d;
  logic               mismatch_q, mismatch_d;
  logic               ewr_q, ewr_d;
  logic               edy_q, edy_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    mismatch_d = mismatch_q;

    case (state_q)
      IDLE: begin
        if (REQ) begin
          wr_d       = WR;
          mismatch_d = 1'b0;
          if (WR) begin
            data_d  = WDATA;
            state_d = W_SETUP;
          end else if (READ_WAIT == 0) begin
            state_d = R_SAMPLE;
          end else begin
            state_d = R_ENABLE;
            cnt_d   = READ_LOAD;
          end
        end
      end
      W_SETUP: begin
        state_d = W_STROBE;
        cnt_d   = STROBE_LOAD;
      end
      W_STROBE: begin
        if (cnt_q == '0) state_d = W_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      W_HOLD: begin
        if (VERIFY == 0) begin
          state_d = DONE;
        end else if (READ_WAIT == 0) begin
          state_d = R_SAMPLE;
        end else begin
          state_d = R_ENABLE;
          cnt_d   = READ_LOAD;
        end
      end
      R_ENABLE: begin
        if (cnt_q == '0) state_d = R_SAMPLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      R_SAMPLE: begin
        rdata_d = REG_IN;
        // Only a write reaching this state is a verify readback.
        if (wr_q) mismatch_d = (REG_IN != data_q);
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies decoded from the next state.
    ewr_d  = (state_d != W_STROBE);
    edy_d  = !((state_d == R_ENABLE) || (state_d == R_SAMPLE));
    busy_d = (state_d != IDLE);
    ack_d  = (state_d == DONE);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      rdata_q    <= '0;
      mismatch_q <= 1'b0;
      ewr_q      <= 1'b1;
      edy_q      <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      mismatch_q <= mismatch_d;
      ewr_q      <= ewr_d;
      edy_q      <= edy_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
    end
  end

  assign DATA_OUT = data_q;
  assign EWR      = ewr_q;
  assign EDY      = edy_q;
  assign BUSY     = busy_q;
  assign ACK      = ack_q;
  assign RDATA    = rdata_q;
  assign MISMATCH = mismatch_q;

endmodule

`default_nettype wire
